// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Stall/bubble controller for the 5-stage MIPS pipeline.
//
// A D-stage instruction is held whenever one of its source registers is still
// being produced by an older instruction in E or M, and that result will not
// be ready by the time D needs it (Tnew > Tuse). A D-stage mult/div-family
// instruction is also held while the multi-cycle mult/div unit is busy, or
// while that unit is being issued from E in the same cycle.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   D_rs, D_rt   source register fields of the D-stage instruction
//   D_Tuse_rs/rt cycles until the source is consumed (3 = not read)
//   D_is_md      D instruction uses the mult/div unit or HI/LO
//   E_A3, E_Tnew destination register / result latency of the E instruction
//   M_A3, M_Tnew destination register / result latency of the M instruction
//   E_md_start   E issues mult/multu/div/divu this cycle
//   E_md_div     the issue is a divide (longer busy window)
//   stall        D stage held this cycle
//   pc_we        PC write enable
//   fd_we        F/D register write enable
//   de_we        D/E load enable; 0 loads a NOP bubble into D/E
//   md_busy      mult/div unit busy
//   stall_cnt    total stall cycles since reset (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        pc_we,
  output logic        fd_we,
  output logic        de_we,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             rs_haz;
  logic             rt_haz;
  logic             md_haz;

  // Register 0 is hardwired, so a write to it is never a real dependency.
  // Tuse=3 marks "not read"; since Tnew never exceeds 2 the compare alone
  // already rules it out.
  assign rs_haz = (D_rs != 5'd0) &&
                  (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                   ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));

  assign rt_haz = (D_rt != 5'd0) &&
                  (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                   ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));

  assign md_busy = (cnt != '0);

  // E_md_start is included so the issue cycle itself is covered, before the
  // countdown has been loaded.
  assign md_haz = D_is_md && (md_busy || E_md_start);

  assign stall = rs_haz || rt_haz || md_haz;
  assign pc_we = ~stall;
  assign fd_we = ~stall;
  assign de_we = ~stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      // A start while already counting cannot happen legally (md_haz holds it
      // in D) and is ignored rather than restarting the window.
      if (E_md_start && (cnt == '0)) begin
        cnt <= E_md_div ? DIV_LOAD : MULT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule
